// File: rtl/aud_codec_emu.sv
// I2S codec-side endpoint (WM8731 master mode). Generates BCLK/LRCK, serializes ADC words, and captures DAC words.
// Latency: ADC MSB appears 1 BCLK after the LRCK edge; o_dac_valid is 1 i_clk after the right-LSB BCLK rise.
// Backpressure: none. o_adc_req asks for the next sample pair. Define AUD_CODEC_EMU_LOOPBACK_EN to replay DAC words on ADC.
module aud_codec_emu #(
    parameter int BCLK_DIV = 2,
    parameter int DATA_W   = 16,
    parameter int SLOT_W   = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_adc_left,
    input  logic [DATA_W-1:0] i_adc_right,
    output logic              o_adc_req,
    output logic              o_AUD_BCLK,
    output logic              o_AUD_ADCLRCK,
    output logic              o_AUD_DACLRCK,
    output logic              o_AUD_ADCDAT,
    input  logic              i_AUD_DACDAT,
    output logic [DATA_W-1:0] o_dac_left,
    output logic [DATA_W-1:0] o_dac_right,
    output logic              o_dac_valid
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_W);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              bclk;
    logic              lrck;
    logic              adcdat;
    logic [DATA_W-1:0] adc_sr_l;
    logic [DATA_W-1:0] adc_sr_r;
    logic [DATA_W-1:0] dac_sr_l;
    logic [DATA_W-1:0] dac_sr_r;
    logic              dac_pend;

    logic              tc;
    logic              rise_stb;
    logic              fall_stb;
    logic [BIT_W-1:0]  cur_b;
    logic              cur_in;
    logic [BIT_W-1:0]  next_cnt;
    logic              next_lrck;
    logic [BIT_W-1:0]  next_b;
    logic              next_in;
    logic [DATA_W-1:0] load_l;
    logic [DATA_W-1:0] load_r;

`ifdef AUD_CODEC_EMU_LOOPBACK_EN
    assign load_l = o_dac_left;
    assign load_r = o_dac_right;
`else
    assign load_l = i_adc_left;
    assign load_r = i_adc_right;
`endif

    // Strobes describe what the coming edge does to BCLK.
    assign tc       = (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign rise_stb = (state == S_RUN) && tc && !bclk;
    assign fall_stb = (state == S_RUN) && tc && bclk;

    // Slot-relative bit index now (for DAC sampling) and after the next fall (for ADC drive).
    assign cur_b     = lrck ? (bit_cnt - BIT_W'(SLOT_W)) : bit_cnt;
    assign cur_in    = (cur_b >= BIT_W'(1)) && (cur_b <= BIT_W'(DATA_W));
    assign next_cnt  = (bit_cnt == BIT_W'(2 * SLOT_W - 1)) ? '0 : bit_cnt + BIT_W'(1);
    assign next_lrck = (next_cnt >= BIT_W'(SLOT_W));
    assign next_b    = next_lrck ? (next_cnt - BIT_W'(SLOT_W)) : next_cnt;
    assign next_in   = (next_b >= BIT_W'(1)) && (next_b <= BIT_W'(DATA_W));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            bclk        <= 1'b0;
            lrck        <= 1'b0;
            adcdat      <= 1'b0;
            adc_sr_l    <= '0;
            adc_sr_r    <= '0;
            dac_sr_l    <= '0;
            dac_sr_r    <= '0;
            dac_pend    <= 1'b0;
            o_adc_req   <= 1'b0;
            o_dac_left  <= '0;
            o_dac_right <= '0;
            o_dac_valid <= 1'b0;
        end else begin
            o_adc_req   <= 1'b0;
            o_dac_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_en) begin
                        state     <= S_RUN;
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
                        lrck      <= 1'b0;
                        adcdat    <= 1'b0;
                        adc_sr_l  <= load_l;
                        adc_sr_r  <= load_r;
                        o_adc_req <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!i_en) begin
                        // Abort drops the partial frame, including a pending DAC update.
                        state    <= S_IDLE;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        bclk     <= 1'b0;
                        lrck     <= 1'b0;
                        adcdat   <= 1'b0;
                        dac_sr_l <= '0;
                        dac_sr_r <= '0;
                        dac_pend <= 1'b0;
                    end else begin
                        div_cnt <= tc ? '0 : div_cnt + DIV_W'(1);
                        if (tc) begin
                            bclk <= ~bclk;
                        end

                        if (rise_stb && cur_in) begin
                            if (lrck) begin
                                dac_sr_r <= {dac_sr_r[DATA_W-2:0], i_AUD_DACDAT};
                                if (cur_b == BIT_W'(DATA_W)) begin
                                    dac_pend <= 1'b1;
                                end
                            end else begin
                                dac_sr_l <= {dac_sr_l[DATA_W-2:0], i_AUD_DACDAT};
                            end
                        end

                        if (dac_pend) begin
                            dac_pend    <= 1'b0;
                            o_dac_left  <= dac_sr_l;
                            o_dac_right <= dac_sr_r;
                            o_dac_valid <= 1'b1;
                        end

                        if (fall_stb) begin
                            bit_cnt <= next_cnt;
                            lrck    <= next_lrck;
                            if (next_cnt == '0) begin
                                adcdat    <= 1'b0;
                                adc_sr_l  <= load_l;
                                adc_sr_r  <= load_r;
                                o_adc_req <= 1'b1;
                            end else if (next_in) begin
                                if (next_lrck) begin
                                    adcdat   <= adc_sr_r[DATA_W-1];
                                    adc_sr_r <= {adc_sr_r[DATA_W-2:0], 1'b0};
                                end else begin
                                    adcdat   <= adc_sr_l[DATA_W-1];
                                    adc_sr_l <= {adc_sr_l[DATA_W-2:0], 1'b0};
                                end
                            end else begin
                                adcdat <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_AUD_BCLK    = bclk;
    assign o_AUD_ADCLRCK = lrck;
    assign o_AUD_DACLRCK = lrck;
    assign o_AUD_ADCDAT  = adcdat;

endmodule
